// File: rtl/axis_frame_source.sv
`timescale 1ns/1ps
// axis_frame_source: packs a free-running sample strobe into fixed-length AXI-Stream frames
// with tlast, FIFO-buffered against tready stalls. Define AXIS_FRAME_SOURCE_RAMP_EN for the ramp test source.
module axis_frame_source #(
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH           = 16,
    parameter int FRAME_LEN              = 64,
    parameter int FIFO_DEPTH             = 16
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_areset,
    input  logic                                  enable,
    input  logic                                  sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0]        sample_data,
`ifdef AXIS_FRAME_SOURCE_RAMP_EN
    input  logic                                  test_mode,
`endif
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic [15:0]                           overflow_count,
    output logic                                  busy
);

    localparam int DW = C_M00_AXIS_TDATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [DW-1:0] sext(input logic signed [SAMPLE_WIDTH-1:0] s);
        logic signed [DW-1:0] w;
        w = DW'(s);
        return w;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t         state;
    logic [DW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    fifo_cnt;
    // Counts beats loaded into the slice, so it equals the accepted-beat count plus any beat in flight.
    logic [CW-1:0]  beat_cnt;

    logic           fifo_empty;
    logic           fifo_full;
    logic           slice_free;
    logic           pop;
    logic           pad;
    logic           push_req;
    logic           push;
    logic           drop;
    logic           beat_last;
    logic           drain_done;
    logic [DW-1:0]  push_data;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign slice_free = !m00_axis_tvalid || m00_axis_tready;
    assign pop        = slice_free && !fifo_empty;
    assign pad        = slice_free && fifo_empty && (state == DRAIN) && (beat_cnt != '0);
    assign push_req   = (state == RUN) && sample_valid;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign beat_last  = (beat_cnt == CW'(FRAME_LEN - 1));
    assign drain_done = fifo_empty && (beat_cnt == '0) &&
                        (!m00_axis_tvalid || (m00_axis_tready && m00_axis_tlast));
    assign m00_axis_tstrb = '1;

`ifdef AXIS_FRAME_SOURCE_RAMP_EN
    logic [DW-1:0] ramp_cnt;

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            ramp_cnt <= '0;
        end else if (state == IDLE && enable) begin
            ramp_cnt <= '0;
        end else if (push) begin
            ramp_cnt <= ramp_cnt + 1'b1;
        end
    end

    assign push_data = test_mode ? ramp_cnt : sext(sample_data);
`else
    assign push_data = sext(sample_data);
`endif

    always_ff @(posedge m00_axis_aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_cnt        <= '0;
            beat_cnt        <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
            overflow_count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop) overflow_count <= sat_inc(overflow_count);
            // Output slice: refill from the FIFO head, or with a zero pad beat while closing a frame.
            if (pop || pad) begin
                m00_axis_tvalid <= 1'b1;
                m00_axis_tdata  <= pop ? fifo_mem[rd_ptr] : '0;
                m00_axis_tlast  <= beat_last;
                beat_cnt        <= beat_last ? '0 : beat_cnt + 1'b1;
            end else if (m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (!enable) begin
                    state <= DRAIN;
                end
                DRAIN: if (drain_done) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
